// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_rr_arbiter_pkg;

    // Arbiter control states; IDLE=0, GRANT=1.
    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Increment an index modulo n without ever forming n itself in a narrow type.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          found
);

    // Walk ptr, ptr+1, ... and take the first requester.
    always_comb begin
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream sink between N producers.
// A grant lasts up to MAX_BURST accepted words or until the owner drops valid,
// followed by one IDLE cycle before the next owner is chosen.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned BITS      = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*BITS-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic [N-1:0]    grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick;
    logic          pick_found;
    logic [PW-1:0] owner;
    logic          xfer;
    logic          rel;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req   (in_valid),
        .ptr   (ptr_q),
        .pick  (pick),
        .found (pick_found)
    );

    // Binary index of the current owner, used to advance the pointer on release.
    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                owner = PW'(i);
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant on request, count transfers, release on burst end or idle owner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StGrant;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                // An idle owner has nothing pending, so releasing cannot break a stall.
                if (!out_valid) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (rel) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = PW'(wrap_inc(32'(owner), N));
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Outputs: combinational mux on the registered grant; everything quiet in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        if (state_q == StGrant) begin
            out_valid = |(in_valid & grant_q);
            in_ready  = grant_q & {N{out_ready}};
            for (int unsigned i = 0; i < N; i++) begin
                if (grant_q[i]) begin
                    out_data = in_data[i*BITS +: BITS];
                end
            end
        end
        xfer  = out_valid && out_ready;
        grant = grant_q;
    end

endmodule
